// File: rtl/booth_div_3_pkg.sv
// ============================================================================
// booth_div_3_pkg : shared widths, FSM encoding and saturation constants
// Rev 1.0
// ============================================================================
`default_nettype none

package booth_div_3_pkg;

  localparam int NW_DEF = 24;
  localparam int DW_DEF = 12;
  localparam int CW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [NW_DEF-1:0] QMAX = 24'h7FFFFF;
  localparam logic [NW_DEF-1:0] QMIN = 24'h800000;

endpackage

`default_nettype wire

// File: rtl/booth_div_step_3.sv
// ============================================================================
// booth_div_step_3 : one combinational restoring-division step
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_div_step_3 #(
  parameter int DW = 12
) (
  input  logic [DW:0]   rem_in,
  input  logic          next_bit,
  input  logic [DW-1:0] dabs,
  output logic [DW:0]   rem_out,
  output logic          q_bit
);

  logic [DW:0]   shifted;
  logic [DW+1:0] trial;

  always_comb begin
    shifted = {rem_in[DW-1:0], next_bit};
    trial   = {1'b0, shifted} - {2'b00, dabs};
    // A set rem_in[DW] means the true shifted value exceeds any divisor.
    q_bit   = rem_in[DW] | ~trial[DW+1];
    rem_out = q_bit ? trial[DW:0] : shifted;
  end

endmodule

`default_nettype wire

// File: rtl/booth_div_3.sv
// ============================================================================
// booth_div_3 : sequential signed restoring divider, fixed 25-cycle latency
// Rev 1.0
// ============================================================================
`default_nettype none

module booth_div_3
  import booth_div_3_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          busy,
  output logic          result_rdy,
  output logic          div_zero,
  output logic          ovf
);

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic          sign_n, sign_d;
  logic          zero_q, ovf_q;
  logic [NW-1:0] qreg;
  logic [DW-1:0] dabs;
  logic [DW:0]   rem;

  logic [NW-1:0] nabs_in;
  logic [DW-1:0] dabs_in;
  logic [DW:0]   rem_next;
  logic          q_bit;
  logic          last_step;

  assign nabs_in   = dividend[NW-1] ? (~dividend + 1'b1) : dividend;
  assign dabs_in   = divisor[DW-1]  ? (~divisor  + 1'b1) : divisor;
  assign last_step = (cnt == CW'(NW-1));

  booth_div_step_3 #(.DW(DW)) u_step (
    .rem_in   (rem),
    .next_bit (qreg[NW-1]),
    .dabs     (dabs),
    .rem_out  (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (en) state_d = CALC;
      CALC:    if (last_step) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sign_n     <= 1'b0;
      sign_d     <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      qreg       <= '0;
      dabs       <= '0;
      rem        <= '0;
      quotient   <= '0;
      remainder  <= '0;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            sign_n <= dividend[NW-1];
            sign_d <= divisor[DW-1];
            qreg   <= nabs_in;
            dabs   <= dabs_in;
            rem    <= '0;
            cnt    <= '0;
            zero_q <= (divisor == '0);
            ovf_q  <= (dividend == QMIN) && (divisor == '1);
            busy   <= 1'b1;
          end
        end
        CALC: begin
          qreg <= {qreg[NW-2:0], q_bit};
          rem  <= rem_next;
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          // Divide-by-zero and the single overflow case both override the
          // iterated result with a saturated quotient and zero remainder.
          if (zero_q) begin
            quotient  <= sign_n ? QMIN : QMAX;
            remainder <= '0;
          end else if (ovf_q) begin
            quotient  <= QMAX;
            remainder <= '0;
          end else begin
            quotient  <= (sign_n ^ sign_d) ? (~qreg + 1'b1) : qreg;
            remainder <= sign_n ? (~rem[DW-1:0] + 1'b1) : rem[DW-1:0];
          end
          div_zero   <= zero_q;
          ovf        <= ovf_q;
          result_rdy <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_div_3.sv
// ============================================================================
// tb_booth_div_3 : directed self-checking bench for booth_div_3
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_booth_div_3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] dividend;
  logic [11:0] divisor;
  logic [23:0] quotient;
  logic [11:0] remainder;
  logic        busy, result_rdy, div_zero, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  booth_div_3 dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .result_rdy (result_rdy),
    .div_zero   (div_zero),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [23:0] n, input logic [11:0] d);
    @(negedge clk);
    dividend = n;
    divisor  = d;
    en       = 1'b1;
  endtask

  // lat counts edges after the accept edge until result_rdy is visible
  task automatic wait_rdy(input string tag, output int lat);
    @(negedge clk);
    en  = 1'b0;
    lat = 0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    while (!result_rdy && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [23:0] n, input logic [11:0] d,
                     input logic [23:0] eq, input logic [11:0] er,
                     input logic ez, input logic eo);
    int lat;
    start(n, d);
    wait_rdy(tag, lat);
    check({tag, ".lat"}, 32'(lat), 32'd25);
    check({tag, ".q"},   32'(quotient), 32'(eq));
    check({tag, ".r"},   32'(remainder), 32'(er));
    check({tag, ".dz"},  32'(div_zero), 32'(ez));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    check({tag, ".bsy0"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, ".pulse"}, 32'(result_rdy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat, gap;
    bit  seen;
    rst      = 1'b1;
    en       = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.q",   32'(quotient), 32'd0);
    check("rst.r",   32'(remainder), 32'd0);
    check("rst.ctl", 32'({busy, result_rdy, div_zero, ovf}), 32'd0);

    run("p7",    24'd1000,    12'd7,     24'd142,     12'd6,     1'b0, 1'b0);
    run("n7",    24'hFFFC18,  12'd7,     24'hFFFF72,  12'hFFA,   1'b0, 1'b0);
    run("pn7",   24'd1000,    12'hFF9,   24'hFFFF72,  12'd6,     1'b0, 1'b0);
    run("max",   24'h7FFFFF,  12'h7FF,   24'd4098,    12'd1,     1'b0, 1'b0);
    run("ovf",   24'h800000,  12'hFFF,   24'h7FFFFF,  12'd0,     1'b0, 1'b1);
    run("dzp",   24'd5,       12'd0,     24'h7FFFFF,  12'd0,     1'b1, 1'b0);
    run("dzn",   24'hFFFFFB,  12'd0,     24'h800000,  12'd0,     1'b1, 1'b0);
    run("d2048", 24'h7FFFFF,  12'h800,   24'hFFF001,  12'h7FF,   1'b0, 1'b0);
    run("min1",  24'h800000,  12'd1,     24'h800000,  12'd0,     1'b0, 1'b0);
    run("small", 24'hFFFFFB,  12'd7,     24'd0,       12'hFFB,   1'b0, 1'b0);

    // en pulses while busy must be ignored
    start(24'd1000, 12'd7);
    @(negedge clk);
    en  = 1'b0;
    lat = 0;
    while (!result_rdy && lat < 60) begin
      @(negedge clk);
      lat++;
      en = 1'b0;
      if (lat == 5 || lat == 10) begin
        en       = 1'b1;
        dividend = 24'd9;
        divisor  = 12'd3;
      end
    end
    check("ovl.lat", 32'(lat), 32'd25);
    check("ovl.q",   32'(quotient), 32'd142);
    check("ovl.r",   32'(remainder), 32'd6);

    // accept in the result_rdy cycle: next result 26 cycles later
    en       = 1'b1;
    dividend = 24'd9;
    divisor  = 12'd3;
    gap = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      en = 1'b0;
      gap++;
      if (gap == 1) seen = result_rdy;
    end while (!result_rdy && gap < 60);
    check("b2b.pulse", 32'(seen), 32'd0);
    check("b2b.gap", 32'(gap), 32'd26);
    check("b2b.q",   32'(quotient), 32'd3);
    check("b2b.r",   32'(remainder), 32'd0);

    // reset in the middle of CALC aborts without a result
    start(24'd1000, 12'd7);
    @(negedge clk);
    en = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abrt.q",   32'(quotient), 32'd0);
    check("abrt.r",   32'(remainder), 32'd0);
    check("abrt.ctl", 32'({busy, result_rdy, div_zero, ovf}), 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_rdy) seen = 1'b1;
    end
    check("abrt.nordy", 32'(seen), 32'd0);

    run("after", 24'd100, 12'd10, 24'd10, 12'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
